fpu_addsub_param: RTL

- Parametrised successor to the team's fixed-format FP adder.
- Performs custom-format floating-point add or subtract, selected per operation, with a valid/ready input handshake and a one-cycle output strobe.
- Rounding is round-to-nearest-even using guard, round and sticky bits, plus magnitude-correct operand swap.
- Multi-cycle FSM datapath; sits between the operand register file and the result/status capture logic.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fpu_round_rne.sv | 17 +
 rtl/fpu_addsub_param.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared states, status codes and exponent helpers for the parametrised FP adder.
package fpu_pkg;

    typedef enum logic [2:0] {IDLE, DECODE, ALIGN, OPERATE, NORMALIZE, ROUND, WRITEBACK} fpu_state_t;

    typedef enum logic [1:0] {EXACT = 2'd0, OVERFLOW = 2'd1, UNDERFLOW = 2'd2, INEXACT = 2'd3} status_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even on a hidden-bit mantissa with guard, round and sticky bits.
module fpu_round_rne #(
    parameter int MAN_W = 21
) (
    input  logic [MAN_W:0] man_i,
    input  logic           g_i,
    input  logic           r_i,
    input  logic           s_i,
    output logic [MAN_W:0] man_o,
    output logic           ovf_o,
    output logic           inexact_o
);

    assign {ovf_o, man_o} = {1'b0, man_i} + {{(MAN_W + 1){1'b0}}, g_i & (r_i | s_i | man_i[0])};
    assign inexact_o = g_i | r_i | s_i;

endmodule

// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: multi-cycle custom-format FP add/subtract with RNE rounding,
// valid/ready input handshake and a one-cycle result strobe.
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 10,
    parameter  int MAN_W = 21,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock_100Khz,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] Op_A_in,
    input  logic [W-1:0] Op_B_in,
    output logic         out_valid,
    output logic [W-1:0] data_out,
    output logic [1:0]   status_out
);

    localparam int M = MAN_W + 1;
    localparam int X = M + 3;
    localparam logic [EXP_W-1:0] EMAX = EXP_W'(exp_max(EXP_W));

    fpu_state_t       state_q;
    status_t          st_q, status_q;
    logic [W-1:0]     a_q, b_q, res_q, data_q;
    logic             sa_q, sb_q, uf_q, out_valid_q;
    logic [EXP_W:0]   e_q;
    logic [EXP_W-1:0] diff_q;
    logic [X-1:0]     ma_q, mb_q;
    logic [X:0]       man_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [M-1:0]     ma, mb;
    logic             swap, spa, spb;
    logic [X-1:0]     b_sh, b_lost, b_al;
    logic [X:0]       sum_d;
    logic [M-1:0]     m_r;
    logic             ovf, inexact;
    logic [EXP_W:0]   e_fin;

    // Zero exponent flushes the operand to zero; magnitude order uses {exp,frac}.
    always_comb begin
        ea   = a_q[W-2:MAN_W];
        eb   = b_q[W-2:MAN_W];
        fa   = (ea == '0) ? '0 : a_q[MAN_W-1:0];
        fb   = (eb == '0) ? '0 : b_q[MAN_W-1:0];
        ma   = (ea == '0) ? '0 : {1'b1, fa};
        mb   = (eb == '0) ? '0 : {1'b1, fb};
        swap = {eb, fb} > {ea, fa};
        spa  = ea == EMAX;
        spb  = eb == EMAX;
    end

    always_comb begin
        b_sh   = mb_q >> diff_q;
        b_lost = mb_q & ((X'(1) << diff_q) - X'(1));
        b_al   = (int'(diff_q) >= MAN_W + 3) ? {{(X-1){1'b0}}, |mb_q}
                                             : b_sh | {{(X-1){1'b0}}, |b_lost};
        sum_d  = (sa_q == sb_q) ? {1'b0, ma_q} + {1'b0, mb_q} : {1'b0, ma_q} - {1'b0, mb_q};
        e_fin  = e_q + {{EXP_W{1'b0}}, ovf};
    end

    fpu_round_rne #(.MAN_W(MAN_W)) u_round (
        .man_i     (man_q[X-1:3]),
        .g_i       (man_q[2]),
        .r_i       (man_q[1]),
        .s_i       (man_q[0]),
        .man_o     (m_r),
        .ovf_o     (ovf),
        .inexact_o (inexact)
    );

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            st_q        <= EXACT;
            status_q    <= EXACT;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            data_q      <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            uf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            e_q         <= '0;
            diff_q      <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            man_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= Op_A_in;
                    b_q     <= {Op_B_in[W-1] ^ op_sub, Op_B_in[W-2:0]};
                    state_q <= DECODE;
                end
                DECODE: if (spa || spb) begin
                    res_q   <= {spa ? a_q[W-1] : b_q[W-1], EMAX,
                                {{(MAN_W-1){1'b0}}, spa & spb & (a_q[W-1] ^ b_q[W-1])}};
                    st_q    <= OVERFLOW;
                    state_q <= WRITEBACK;
                end else begin
                    sa_q    <= swap ? b_q[W-1] : a_q[W-1];
                    sb_q    <= swap ? a_q[W-1] : b_q[W-1];
                    e_q     <= {1'b0, swap ? eb : ea};
                    diff_q  <= swap ? eb - ea : ea - eb;
                    ma_q    <= {swap ? mb : ma, 3'b000};
                    mb_q    <= {swap ? ma : mb, 3'b000};
                    state_q <= ALIGN;
                end
                ALIGN: begin
                    mb_q    <= b_al;
                    state_q <= OPERATE;
                end
                OPERATE: if (sum_d == '0) begin
                    res_q   <= {sa_q & sb_q, {(W-1){1'b0}}};
                    st_q    <= EXACT;
                    state_q <= WRITEBACK;
                end else begin
                    man_q   <= sum_d;
                    state_q <= NORMALIZE;
                end
                NORMALIZE: if (man_q[X]) begin
                    man_q <= {1'b0, man_q[X:2], man_q[1] | man_q[0]};
                    e_q   <= e_q + (EXP_W+1)'(1);
                end else if (!man_q[X-1] && e_q > (EXP_W+1)'(1)) begin
                    man_q <= man_q << 1;
                    e_q   <= e_q - (EXP_W+1)'(1);
                end else begin
                    uf_q    <= !man_q[X-1];
                    state_q <= ROUND;
                end
                ROUND: begin
                    if (e_fin >= {1'b0, EMAX}) begin
                        res_q <= {sa_q, EMAX, {MAN_W{1'b0}}};
                        st_q  <= OVERFLOW;
                    end else if (uf_q && !m_r[M-1]) begin
                        res_q <= {sa_q, {(W-1){1'b0}}};
                        st_q  <= UNDERFLOW;
                    end else begin
                        res_q <= {sa_q, e_fin[EXP_W-1:0], m_r[MAN_W-1:0]};
                        st_q  <= inexact ? INEXACT : EXACT;
                    end
                    state_q <= WRITEBACK;
                end
                WRITEBACK: begin
                    data_q      <= res_q;
                    status_q    <= st_q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule
